// File: rtl/hazard_fwd_scoreboard.sv
// Forwarding-source select and load-use stall for the RV32I pipeline.
// A private shadow of EX and the FWD_DEPTH later stages tracks which registers are still in flight.
module hazard_fwd_scoreboard #(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 5,
  parameter int FWD_DEPTH    = 2,
  parameter int LOAD_LAT     = 1,
  parameter int CNT_W        = 32,
  localparam int SEL_W       = $clog2(FWD_DEPTH + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_id_valid,
  input  logic [NUM_RD_PORTS*REG_AW-1:0] i_id_rs,
  input  logic [NUM_RD_PORTS-1:0]        i_id_rs_used,
  input  logic [REG_AW-1:0]              i_id_rd,
  input  logic                           i_id_reg_write,
  input  logic                           i_id_mem_read,
  input  logic                           i_flush,
  output logic                           o_stall,
  output logic [NUM_RD_PORTS*SEL_W-1:0]  o_fwd_sel,
  output logic [CNT_W-1:0]               o_stall_count
);

  logic                           r_ex_v;
  logic                           r_ex_we;
  logic                           r_ex_ld;
  logic [NUM_RD_PORTS*REG_AW-1:0] r_ex_rs;
  logic [NUM_RD_PORTS-1:0]        r_ex_rs_used;
  logic [REG_AW-1:0]              r_ex_rd;

  logic [FWD_DEPTH:1]             r_s_v;
  logic [FWD_DEPTH:1]             r_s_we;
  logic [FWD_DEPTH:1]             r_s_ld;
  logic [FWD_DEPTH:1][REG_AW-1:0] r_s_rd;

  logic [CNT_W-1:0]               r_stall_count;

  // Producer view by distance: 1 is EX, k+1 is shadow stage k.
  logic [FWD_DEPTH+1:1]             w_p_v;
  logic [FWD_DEPTH+1:1]             w_p_we;
  logic [FWD_DEPTH+1:1]             w_p_ld;
  logic [FWD_DEPTH+1:1][REG_AW-1:0] w_p_rd;

  logic                          w_stall;
  logic [NUM_RD_PORTS*SEL_W-1:0] w_fwd_sel;
  logic [REG_AW-1:0]             w_id_rs_p;
  logic                          w_id_hit;
  logic [REG_AW-1:0]             w_ex_rs_p;
  logic                          w_ex_hit;

  always_comb begin
    w_p_v[1]  = r_ex_v;
    w_p_we[1] = r_ex_we;
    w_p_ld[1] = r_ex_ld;
    w_p_rd[1] = r_ex_rd;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      w_p_v[k+1]  = r_s_v[k];
      w_p_we[k+1] = r_s_we[k];
      w_p_ld[k+1] = r_s_ld[k];
      w_p_rd[k+1] = r_s_rd[k];
    end
  end

  // Only the youngest matching producer decides; an older load behind a younger ALU write is harmless.
  always_comb begin
    w_stall   = 1'b0;
    w_id_rs_p = '0;
    w_id_hit  = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      w_id_rs_p = i_id_rs[p*REG_AW +: REG_AW];
      w_id_hit  = 1'b0;
      for (int d = 1; d <= FWD_DEPTH + 1; d++) begin
        if (!w_id_hit && w_p_v[d] && w_p_we[d] && (w_p_rd[d] == w_id_rs_p) && (w_id_rs_p != '0)) begin
          w_id_hit = 1'b1;
          if (w_p_ld[d] && (d <= LOAD_LAT) && i_id_valid && i_id_rs_used[p])
            w_stall = 1'b1;
        end
      end
    end
    if (i_flush || i_rst)
      w_stall = 1'b0;
  end

  always_comb begin
    w_fwd_sel = '0;
    w_ex_rs_p = '0;
    w_ex_hit  = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      w_ex_rs_p = r_ex_rs[p*REG_AW +: REG_AW];
      w_ex_hit  = 1'b0;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        if (!w_ex_hit && r_ex_v && r_ex_rs_used[p] && r_s_v[k] && r_s_we[k] &&
            (r_s_rd[k] == w_ex_rs_p) && (w_ex_rs_p != '0)) begin
          w_ex_hit = 1'b1;
          w_fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
    if (i_rst)
      w_fwd_sel = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_v        <= 1'b0;
      r_s_v         <= '0;
      r_stall_count <= '0;
    end else begin
      r_s_v[1]  <= r_ex_v;
      r_s_we[1] <= r_ex_we;
      r_s_ld[1] <= r_ex_ld;
      r_s_rd[1] <= r_ex_rd;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        r_s_v[k]  <= r_s_v[k-1];
        r_s_we[k] <= r_s_we[k-1];
        r_s_ld[k] <= r_s_ld[k-1];
        r_s_rd[k] <= r_s_rd[k-1];
      end
      // Payload always loads; a bubble is marked only by a cleared valid.
      r_ex_v       <= i_id_valid && !i_flush && !w_stall;
      r_ex_we      <= i_id_reg_write;
      r_ex_ld      <= i_id_mem_read;
      r_ex_rs      <= i_id_rs;
      r_ex_rs_used <= i_id_rs_used;
      r_ex_rd      <= i_id_rd;
      if (w_stall && !(&r_stall_count))
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign o_stall       = w_stall;
  assign o_fwd_sel     = w_fwd_sel;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard: a default instance and a deep-load, 4-bit-counter instance,
// both checked every cycle against a history-log reference model, plus directed vector tables.
module tb_hazard_fwd_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, idv, we, ld, flush;
  logic [9:0] rs;
  logic [1:0] used;
  logic [4:0] rd;

  logic        stall_a, stall_b;
  logic [3:0]  fwd_a, fwd_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  hazard_fwd_scoreboard u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_id_valid(idv), .i_id_rs(rs), .i_id_rs_used(used),
    .i_id_rd(rd), .i_id_reg_write(we), .i_id_mem_read(ld), .i_flush(flush),
    .o_stall(stall_a), .o_fwd_sel(fwd_a), .o_stall_count(cnt_a)
  );

  hazard_fwd_scoreboard #(.FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_id_valid(idv), .i_id_rs(rs), .i_id_rs_used(used),
    .i_id_rd(rd), .i_id_reg_write(we), .i_id_mem_read(ld), .i_flush(flush),
    .o_stall(stall_b), .o_fwd_sel(fwd_b), .o_stall_count(cnt_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a log of everything that entered EX, one slot per clock edge.
  typedef struct {
    logic       v, we, ld;
    logic [1:0] used;
    logic [4:0] rs0, rs1, rd;
  } ent_t;

  ent_t   log_m[2][8];
  int     ptr_m[2];
  longint cnt_m[2];

  function automatic int fd(input int m);  return (m == 0) ? 2 : 3; endfunction
  function automatic int ll(input int m);  return (m == 0) ? 1 : 2; endfunction
  function automatic longint cmax(input int m);
    return (m == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  function automatic ent_t hist(input int m, input int d);
    return log_m[m][(ptr_m[m] - d + 1) & 7];
  endfunction

  function automatic int youngest(input int m, input logic [4:0] r);
    for (int d = 1; d <= fd(m) + 1; d++) begin
      ent_t e = hist(m, d);
      if (e.v && e.we && e.rd == r && r != 5'd0) return d;
    end
    return 0;
  endfunction

  function automatic bit model_stall(input int m);
    if (rst || flush || !idv) return 1'b0;
    for (int p = 0; p < 2; p++) begin
      logic [4:0] r = (p == 0) ? rs[4:0] : rs[9:5];
      if (used[p]) begin
        int   d = youngest(m, r);
        ent_t e;
        if (d > 0) begin
          e = hist(m, d);
          if (d <= ll(m) && e.ld) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic int model_fwd(input int m, input int p);
    ent_t       ex;
    logic [4:0] r;
    if (rst) return 0;
    ex = hist(m, 1);
    if (!ex.v || !ex.used[p]) return 0;
    r = (p == 0) ? ex.rs0 : ex.rs1;
    for (int k = 1; k <= fd(m); k++) begin
      ent_t e = hist(m, k + 1);
      if (e.v && e.we && e.rd == r && r != 5'd0) return k;
    end
    return 0;
  endfunction

  task automatic model_update(input int m, input bit s);
    ent_t n;
    if (rst) begin
      for (int i = 0; i < 8; i++) log_m[m][i].v = 1'b0;
      cnt_m[m] = 0;
    end else begin
      n.v    = idv && !flush && !s;
      n.we   = we;
      n.ld   = ld;
      n.used = used;
      n.rs0  = rs[4:0];
      n.rs1  = rs[9:5];
      n.rd   = rd;
      ptr_m[m]++;
      log_m[m][ptr_m[m] & 7] = n;
      if (s && cnt_m[m] != cmax(m)) cnt_m[m]++;
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    check("a.stall", 64'(stall_a),   64'(model_stall(0)));
    check("a.fwd0",  64'(fwd_a[1:0]), 64'(model_fwd(0, 0)));
    check("a.fwd1",  64'(fwd_a[3:2]), 64'(model_fwd(0, 1)));
    check("a.cnt",   64'(cnt_a),     64'(cnt_m[0]));
    check("b.stall", 64'(stall_b),   64'(model_stall(1)));
    check("b.fwd0",  64'(fwd_b[1:0]), 64'(model_fwd(1, 0)));
    check("b.fwd1",  64'(fwd_b[3:2]), 64'(model_fwd(1, 1)));
    check("b.cnt",   64'(cnt_b),     64'(cnt_m[1]));
  endtask

  task automatic to_pos();
    bit s0 = model_stall(0);
    bit s1 = model_stall(1);
    @(posedge clk);
    model_update(0, s0);
    model_update(1, s1);
    #1;
  endtask

  typedef struct {
    bit         r, fl, v;
    logic [4:0] s0, s1;
    logic [1:0] u;
    logic [4:0] rd;
    bit         we, ld;
    bit         e_st;
    logic [1:0] e_f0, e_f1;
    int         e_cnt;
  } vec_t;

  function automatic vec_t mk(input bit r, fl, v, input logic [4:0] s0, s1, input logic [1:0] u,
                              input logic [4:0] d, input bit w, l, input bit st,
                              input logic [1:0] f0, f1, input int c);
    vec_t t;
    t.r = r; t.fl = fl; t.v = v; t.s0 = s0; t.s1 = s1; t.u = u; t.rd = d; t.we = w; t.ld = l;
    t.e_st = st; t.e_f0 = f0; t.e_f1 = f1; t.e_cnt = c;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    rst = t.r; flush = t.fl; idv = t.v; rs = {t.s1, t.s0}; used = t.u;
    rd = t.rd; we = t.we; ld = t.ld;
  endtask

  vec_t tbl[$];
  vec_t hand[$];
  vec_t nop;
  vec_t lw6;

  initial begin
    nop = mk(0,0,0, 0,0,2'b00, 0,0,0, 0,0,0,0);
    rst = 1'b1; flush = 1'b0; idv = 1'b0; rs = '0; used = '0; rd = '0; we = 1'b0; ld = 1'b0;
    to_pos();

    //                rst fl v  s0 s1 used  rd we ld  st f0 f1 cnt   (expectations for default instance)
    tbl.push_back(mk(1, 0, 1,  5, 5, 2'b11, 5, 1, 1,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  6, 7, 2'b11, 6, 1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  1, 2, 2'b11, 5, 1, 0,  0, 0, 0, 0));   // add x5
    tbl.push_back(mk(0, 0, 1,  5, 3, 2'b11, 8, 1, 0,  0, 0, 0, 0));   // sub rs1=x5
    tbl.push_back(nop);  tbl[$].e_f0 = 2'd1;
    tbl.push_back(mk(0, 0, 1,  1, 2, 2'b11, 5, 1, 0,  0, 0, 0, 0));   // add x5
    tbl.push_back(nop);
    tbl.push_back(mk(0, 0, 1,  5, 9, 2'b11,10, 1, 0,  0, 0, 0, 0));   // consumer one later
    tbl.push_back(nop);  tbl[$].e_f0 = 2'd2;
    tbl.push_back(mk(0, 0, 1,  1, 0, 2'b01, 6, 1, 1,  0, 0, 0, 0));   // lw x6
    tbl.push_back(mk(0, 0, 1,  4, 6, 2'b11,11, 1, 0,  1, 0, 0, 0));   // add rs2=x6: stall
    tbl.push_back(mk(0, 0, 1,  4, 6, 2'b11,11, 1, 0,  0, 0, 0, 1));   // held, bubble in EX
    tbl.push_back(nop);  tbl[$].e_f1 = 2'd2; tbl[$].e_cnt = 1;
    tbl.push_back(mk(0, 0, 1,  1, 0, 2'b01, 7, 1, 0,  0, 0, 0, 1));   // x7 (older)
    tbl.push_back(mk(0, 0, 1,  2, 0, 2'b01, 7, 1, 0,  0, 0, 0, 1));   // x7 (younger)
    tbl.push_back(mk(0, 0, 1,  7, 0, 2'b11,12, 1, 0,  0, 0, 0, 1));
    tbl.push_back(nop);  tbl[$].e_f0 = 2'd1; tbl[$].e_cnt = 1;
    tbl.push_back(mk(0, 0, 1,  3, 0, 2'b01, 0, 1, 0,  0, 0, 0, 1));   // writes x0
    tbl.push_back(mk(0, 0, 1,  0, 0, 2'b11,13, 1, 0,  0, 0, 0, 1));   // reads x0
    tbl.push_back(nop);  tbl[$].e_cnt = 1;
    tbl.push_back(mk(0, 0, 1,  1, 0, 2'b01, 6, 1, 1,  0, 0, 0, 1));   // lw x6
    tbl.push_back(mk(0, 1, 1,  6, 6, 2'b11,14, 1, 0,  0, 0, 0, 1));   // load-use with flush
    tbl.push_back(nop);  tbl[$].e_cnt = 1;
    tbl.push_back(mk(0, 0, 1,  1, 0, 2'b01, 9, 1, 1,  0, 0, 0, 1));   // lw x9
    tbl.push_back(mk(0, 0, 1,  9, 2, 2'b10,15, 1, 0,  0, 0, 0, 1));   // x9 on unused port
    tbl.push_back(nop);  tbl[$].e_cnt = 1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      to_neg();
      check($sformatf("vec%0d.stall", i), 64'(stall_a),    64'(tbl[i].e_st));
      check($sformatf("vec%0d.fwd0", i),  64'(fwd_a[1:0]), 64'(tbl[i].e_f0));
      check($sformatf("vec%0d.fwd1", i),  64'(fwd_a[3:2]), 64'(tbl[i].e_f1));
      check($sformatf("vec%0d.cnt", i),   64'(cnt_a),      64'(tbl[i].e_cnt));
      to_pos();
    end

    // Deep-load instance: two stall cycles, then forward from stage 3.
    hand.push_back(mk(1, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0));
    hand.push_back(mk(0, 0, 1,  1, 0, 2'b01, 6, 1, 1,  0, 0, 0, 0));
    hand.push_back(mk(0, 0, 1,  4, 6, 2'b11,11, 1, 0,  1, 0, 0, 0));
    hand.push_back(mk(0, 0, 1,  4, 6, 2'b11,11, 1, 0,  1, 0, 0, 1));
    hand.push_back(mk(0, 0, 1,  4, 6, 2'b11,11, 1, 0,  0, 0, 0, 2));
    hand.push_back(nop);  hand[$].e_f1 = 2'd3; hand[$].e_cnt = 2;
    foreach (hand[i]) begin
      apply(hand[i]);
      to_neg();
      if (i > 0) begin
        check($sformatf("deep%0d.stall", i), 64'(stall_b),    64'(hand[i].e_st));
        check($sformatf("deep%0d.fwd0", i),  64'(fwd_b[1:0]), 64'(hand[i].e_f0));
        check($sformatf("deep%0d.fwd1", i),  64'(fwd_b[3:2]), 64'(hand[i].e_f1));
        check($sformatf("deep%0d.cnt", i),   64'(cnt_b),      64'(hand[i].e_cnt));
      end
      to_pos();
    end

    // Saturation: a self-dependent load chain stalls the deep instance two cycles out of three.
    apply(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    to_neg(); to_pos();
    lw6 = mk(0, 0, 1, 6, 0, 2'b01, 6, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      apply(lw6);
      to_neg(); to_pos();
    end
    to_neg();
    check("sat.cnt", 64'(cnt_b), 64'd15);
    to_pos();
    for (int i = 0; i < 5; i++) begin
      to_neg(); to_pos();
    end
    to_neg();
    check("sat.hold", 64'(cnt_b), 64'd15);
    to_pos();

    // Random traffic with a small register set so dependencies are common.
    for (int i = 0; i < 1500; i++) begin
      if (!(model_stall(0) && $urandom_range(0, 3) != 0)) begin
        idv  = ($urandom_range(0, 3) != 0);
        rs   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        used = 2'($urandom_range(0, 3));
        rd   = 5'($urandom_range(0, 7));
        we   = ($urandom_range(0, 3) != 0);
        ld   = ($urandom_range(0, 2) == 0);
      end
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      to_neg();
      to_pos();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
